// File: rtl/atm_pkg.sv
// atm_pkg: shared types and width helpers for the ATM session controller.
// State encodings are fixed; widths derive from the counted cycle limits.
package atm_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PIN    = 3'd1,
        S_MENU   = 3'd2,
        S_TXN    = 3'd3,
        S_EJECT  = 3'd4,
        S_RETAIN = 3'd5
    } state_t;

    localparam int TIMEOUT_DEF = 5;
    localparam int TRIES_DEF   = 3;
    localparam int LOCK_DEF    = 20;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int INACT_W = cnt_w(TIMEOUT_DEF);
    localparam int LOCK_W  = cnt_w(LOCK_DEF);

endpackage

// File: rtl/atm_inact_timer.sv
// atm_inact_timer: inactivity counter with terminal-count detect.
// Define ATM_TIMEOUT_WARN_EN to add the early-warning output.
module atm_inact_timer
    import atm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    input  logic restart,
    output logic timeout
`ifdef ATM_TIMEOUT_WARN_EN
    , output logic warn
`endif
);

    localparam int IW = cnt_w(TIMEOUT_CYCLES);
    localparam logic [IW-1:0] TERM = IW'(TIMEOUT_CYCLES - 1);

    logic [IW-1:0] cnt;

    // A keypress on the terminal cycle wins over the timeout.
    assign timeout = enable & ~clear & (cnt == TERM);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (!enable || clear || restart || timeout) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef ATM_TIMEOUT_WARN_EN
    localparam logic [IW-1:0] WARN_AT = IW'(TIMEOUT_CYCLES - 2);

    assign warn = enable & (cnt >= WARN_AT);
`endif

endmodule

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: ATM customer session sequencer with PIN lockout.
// Define ATM_TIMEOUT_WARN_EN to expose timeout_warn.
module atm_session_ctrl
    import atm_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
    parameter int MAX_PIN_TRIES  = TRIES_DEF,
    parameter int LOCK_CYCLES    = LOCK_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       card_in,
    input  logic       pin_valid,
    input  logic       pin_ok,
    input  logic       key_activity,
    input  logic       txn_req,
    input  logic       txn_done,
    output logic [2:0] state,
    output logic       session_active,
    output logic [2:0] pin_err_cnt,
    output logic       timeout_evt,
    output logic       txn_abort,
    output logic       card_retain
`ifdef ATM_TIMEOUT_WARN_EN
    , output logic     timeout_warn
`endif
);

    localparam int LW = cnt_w(LOCK_CYCLES);
    localparam logic [LW-1:0] LTERM = LW'(LOCK_CYCLES - 1);
    localparam logic [2:0] MAXP = 3'(MAX_PIN_TRIES);

    state_t st, st_n;
    logic [2:0] err_q, err_n;
    logic [LW-1:0] lock_q, lock_n;
    logic tev_q, tev_n;
    logic abt_q, abt_n;
    logic active, key_clr, tmo_hit, retry, restart;

    assign active  = (st == S_PIN) || (st == S_MENU) || (st == S_TXN);
    assign key_clr = key_activity && ((st == S_PIN) || (st == S_MENU));
    assign restart = (st_n != st) || retry;

    atm_inact_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (active),
        .clear  (key_clr),
        .restart(restart),
        .timeout(tmo_hit)
`ifdef ATM_TIMEOUT_WARN_EN
        , .warn (timeout_warn)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st     <= S_IDLE;
            err_q  <= '0;
            lock_q <= '0;
            tev_q  <= 1'b0;
            abt_q  <= 1'b0;
        end else begin
            st     <= st_n;
            err_q  <= err_n;
            lock_q <= lock_n;
            tev_q  <= tev_n;
            abt_q  <= abt_n;
        end
    end

    always_comb begin
        st_n  = st;
        err_n = err_q;
        retry = 1'b0;
        tev_n = 1'b0;
        abt_n = 1'b0;
        unique case (st)
            S_IDLE: begin
                if (card_in) begin
                    st_n  = S_PIN;
                    err_n = '0;
                end
            end
            S_PIN: begin
                if (!card_in) begin
                    st_n = S_IDLE;
                end else if (tmo_hit) begin
                    st_n  = S_EJECT;
                    tev_n = 1'b1;
                end else if (pin_valid && pin_ok) begin
                    st_n = S_MENU;
                end else if (pin_valid) begin
                    err_n = (err_q >= MAXP) ? MAXP : err_q + 3'd1;
                    if (err_n == MAXP) begin
                        st_n = S_RETAIN;
                    end else begin
                        retry = 1'b1;
                    end
                end
            end
            S_MENU: begin
                if (!card_in) begin
                    st_n = S_IDLE;
                end else if (tmo_hit) begin
                    st_n  = S_EJECT;
                    tev_n = 1'b1;
                end else if (txn_req) begin
                    st_n = S_TXN;
                end
            end
            // Card stays locked in the reader until the datapath is done.
            S_TXN: begin
                if (txn_done) begin
                    st_n = S_MENU;
                end else if (tmo_hit) begin
                    st_n  = S_EJECT;
                    tev_n = 1'b1;
                    abt_n = 1'b1;
                end
            end
            S_EJECT: begin
                if (!card_in) begin
                    st_n = S_IDLE;
                end
            end
            S_RETAIN: begin
                if (lock_q == LTERM) begin
                    st_n  = S_IDLE;
                    err_n = '0;
                end
            end
            default: begin
                st_n = S_IDLE;
            end
        endcase
        lock_n = ((st == S_RETAIN) && (st_n == S_RETAIN))
               ? lock_q + 1'b1 : '0;
    end

    always_comb begin
        state          = st;
        session_active = active;
        pin_err_cnt    = err_q;
        timeout_evt    = tev_q;
        txn_abort      = abt_q;
        card_retain    = (st == S_RETAIN);
    end

endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: scoreboard bench for the ATM session sequencer.
// Each scenario queues stimulus rows; expectations are compared per cycle.
module tb_atm_session_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic card_in, pin_valid, pin_ok, key_activity, txn_req, txn_done;
    logic [2:0] state;
    logic session_active;
    logic [2:0] pin_err_cnt;
    logic timeout_evt, txn_abort, card_retain;
`ifdef ATM_TIMEOUT_WARN_EN
    logic timeout_warn;
`endif

    atm_session_ctrl #(
        .TIMEOUT_CYCLES(5),
        .MAX_PIN_TRIES (3),
        .LOCK_CYCLES   (20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .card_in       (card_in),
        .pin_valid     (pin_valid),
        .pin_ok        (pin_ok),
        .key_activity  (key_activity),
        .txn_req       (txn_req),
        .txn_done      (txn_done),
        .state         (state),
        .session_active(session_active),
        .pin_err_cnt   (pin_err_cnt),
        .timeout_evt   (timeout_evt),
        .txn_abort     (txn_abort),
        .card_retain   (card_retain)
`ifdef ATM_TIMEOUT_WARN_EN
        , .timeout_warn(timeout_warn)
`endif
    );

    always #5 clk = ~clk;

    localparam logic [5:0] C   = 6'b100000;
    localparam logic [5:0] PV  = 6'b010000;
    localparam logic [5:0] POK = 6'b001000;
    localparam logic [5:0] K   = 6'b000100;
    localparam logic [5:0] R   = 6'b000010;
    localparam logic [5:0] D   = 6'b000001;

    typedef struct packed {
        logic [2:0] st;
        logic       act;
        logic [2:0] err;
        logic       tev;
        logic       abt;
        logic       ret;
    } exp_t;

    typedef struct packed {
        logic [5:0] stim;
        exp_t       exp;
    } row_t;

    row_t plan[$];
    exp_t sb[$];
    int n_chk = 0;
    int n_err = 0;

    function automatic exp_t mk(input logic [2:0] s, input logic [2:0] e,
                                input logic t, input logic a);
        exp_t r;
        r.st  = s;
        r.act = (s == 3'd1) || (s == 3'd2) || (s == 3'd3);
        r.err = e;
        r.tev = t;
        r.abt = a;
        r.ret = (s == 3'd5);
        return r;
    endfunction

    function automatic exp_t obs();
        exp_t r;
        r.st  = state;
        r.act = session_active;
        r.err = pin_err_cnt;
        r.tev = timeout_evt;
        r.abt = txn_abort;
        r.ret = card_retain;
        return r;
    endfunction

    function automatic string fmt(input exp_t x);
        return $sformatf("st=%0d err=%0d act=%b tev=%b abt=%b ret=%b",
                         x.st, x.err, x.act, x.tev, x.abt, x.ret);
    endfunction

    task automatic drive(input logic [5:0] s);
        {card_in, pin_valid, pin_ok, key_activity, txn_req, txn_done} = s;
    endtask

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic [5:0] s, input logic [2:0] st,
                       input logic [2:0] e, input logic t, input logic a);
        row_t r;
        r.stim = s;
        r.exp  = mk(st, e, t, a);
        plan.push_back(r);
    endtask

    task automatic test_reset();
        exp_t o;
        rst = 1'b1;
        drive(6'b0);
        clk1();
        clk1();
        o = obs();
        n_chk++;
        if (o !== mk(0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL reset got %s want %s", fmt(o), fmt(mk(0, 0, 0, 0)));
        end
        @(negedge clk);
        rst = 1'b0;
        add(6'b0, 0, 0, 0, 0);
        add(PV | POK | K | R | D, 0, 0, 0, 0);
        while (plan.size() > 0) begin
            row_t r;
            exp_t e;
            r = plan.pop_front();
            drive(r.stim);
            sb.push_back(r.exp);
            clk1();
            e = sb.pop_front();
            o = obs();
            n_chk++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset_idle got %s want %s", fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_happy();
        exp_t o, e;
        row_t r;
        add(C, 1, 0, 0, 0);
        add(C, 1, 0, 0, 0);
        add(C | PV | POK, 2, 0, 0, 0);
        add(C | R, 3, 0, 0, 0);
        add(C | D, 2, 0, 0, 0);
        add(6'b0, 0, 0, 0, 0);
        for (int i = 0; plan.size() > 0; i++) begin
            r = plan.pop_front();
            drive(r.stim);
            sb.push_back(r.exp);
            clk1();
            e = sb.pop_front();
            o = obs();
            n_chk++;
            if (o !== e) begin
                n_err++;
                $display("FAIL happy row%0d got %s want %s", i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_pin_timeout();
        exp_t o, e;
        row_t r;
        add(C, 1, 0, 0, 0);
        repeat (4) add(C, 1, 0, 0, 0);
        add(C, 4, 0, 1, 0);
        repeat (8) add(C, 4, 0, 0, 0);
        add(6'b0, 0, 0, 0, 0);
        for (int i = 0; plan.size() > 0; i++) begin
            r = plan.pop_front();
            drive(r.stim);
            sb.push_back(r.exp);
            clk1();
            e = sb.pop_front();
            o = obs();
            n_chk++;
            if (o !== e) begin
                n_err++;
                $display("FAIL pin_timeout row%0d got %s want %s",
                         i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_activity();
        exp_t o, e;
        row_t r;
        add(C, 1, 0, 0, 0);
        add(C | PV | POK, 2, 0, 0, 0);
        for (int i = 1; i <= 40; i++) begin
            add((i % 4 == 0) ? (C | K) : C, 2, 0, 0, 0);
        end
        repeat (4) add(C, 2, 0, 0, 0);
        add(C | K, 2, 0, 0, 0);
        repeat (4) add(C, 2, 0, 0, 0);
        add(C, 4, 0, 1, 0);
        add(6'b0, 0, 0, 0, 0);
        for (int i = 0; plan.size() > 0; i++) begin
            r = plan.pop_front();
            drive(r.stim);
            sb.push_back(r.exp);
            clk1();
            e = sb.pop_front();
            o = obs();
            n_chk++;
            if (o !== e) begin
                n_err++;
                $display("FAIL activity row%0d got %s want %s",
                         i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_lockout();
        exp_t o, e;
        row_t r;
        logic [5:0] s;
        add(C, 1, 0, 0, 0);
        add(C | PV, 1, 1, 0, 0);
        add(C, 1, 1, 0, 0);
        add(C | PV, 1, 2, 0, 0);
        add(C | PV, 5, 3, 0, 0);
        for (int i = 0; i < 19; i++) begin
            s = ((i % 2) != 0) ? C : 6'b0;
            if (i % 3 == 0) s = s | PV | POK | K;
            add(s, 5, 3, 0, 0);
        end
        add(6'b0, 0, 0, 0, 0);
        add(6'b0, 0, 0, 0, 0);
        for (int i = 0; plan.size() > 0; i++) begin
            r = plan.pop_front();
            drive(r.stim);
            sb.push_back(r.exp);
            clk1();
            e = sb.pop_front();
            o = obs();
            n_chk++;
            if (o !== e) begin
                n_err++;
                $display("FAIL lockout row%0d got %s want %s",
                         i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_txn_abort();
        exp_t o, e;
        row_t r;
        add(C, 1, 0, 0, 0);
        add(C | PV | POK, 2, 0, 0, 0);
        add(C | R, 3, 0, 0, 0);
        repeat (4) add(6'b0, 3, 0, 0, 0);
        add(6'b0, 4, 0, 1, 1);
        add(6'b0, 0, 0, 0, 0);
        add(C, 1, 0, 0, 0);
        add(C | PV | POK, 2, 0, 0, 0);
        add(C | R, 3, 0, 0, 0);
        repeat (4) add(C, 3, 0, 0, 0);
        add(C | D, 2, 0, 0, 0);
        add(C, 2, 0, 0, 0);
        add(6'b0, 0, 0, 0, 0);
        for (int i = 0; plan.size() > 0; i++) begin
            r = plan.pop_front();
            drive(r.stim);
            sb.push_back(r.exp);
            clk1();
            e = sb.pop_front();
            o = obs();
            n_chk++;
            if (o !== e) begin
                n_err++;
                $display("FAIL txn_abort row%0d got %s want %s",
                         i, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_async_reset();
        exp_t o, e;
        row_t r;
        add(C, 1, 0, 0, 0);
        add(C | PV, 1, 1, 0, 0);
        add(C | PV | POK, 2, 1, 0, 0);
        add(C | R, 3, 1, 0, 0);
        repeat (3) add(C, 3, 1, 0, 0);
        for (int i = 0; plan.size() > 0; i++) begin
            r = plan.pop_front();
            drive(r.stim);
            sb.push_back(r.exp);
            clk1();
            e = sb.pop_front();
            o = obs();
            n_chk++;
            if (o !== e) begin
                n_err++;
                $display("FAIL arst_pre row%0d got %s want %s",
                         i, fmt(o), fmt(e));
            end
        end
        drive(C);
        #2;
        rst = 1'b1;
        #1;
        o = obs();
        n_chk++;
        if (o !== mk(0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL arst_now got %s want %s", fmt(o), fmt(mk(0, 0, 0, 0)));
        end
        clk1();
        clk1();
        o = obs();
        n_chk++;
        if (o !== mk(0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL arst_hold got %s want %s", fmt(o), fmt(mk(0, 0, 0, 0)));
        end
        @(negedge clk);
        rst = 1'b0;
        add(C, 1, 0, 0, 0);
        add(6'b0, 0, 0, 0, 0);
        for (int i = 0; plan.size() > 0; i++) begin
            r = plan.pop_front();
            drive(r.stim);
            sb.push_back(r.exp);
            clk1();
            e = sb.pop_front();
            o = obs();
            n_chk++;
            if (o !== e) begin
                n_err++;
                $display("FAIL arst_post row%0d got %s want %s",
                         i, fmt(o), fmt(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_happy();
        test_pin_timeout();
        test_activity();
        test_lockout();
        test_txn_abort();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
